// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register: occupancy state encoding
// and the width of the occupancy count.
package pipe_pkg;

  localparam int unsigned PIPE_CNT_W = 2;

  typedef enum logic [PIPE_CNT_W-1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg_ctrl.sv
// Occupancy FSM for the two-entry skid register. Handshake outputs are
// registered from the next state so no input reaches an output combinationally.
module pipe_skid_reg_ctrl
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  squash,
  input  logic                  istream_val,
  output logic                  istream_rdy,
  output logic                  ostream_val,
  input  logic                  ostream_rdy,
  output logic [PIPE_CNT_W-1:0] count,
  output logic                  m_en,
  output logic                  s_en,
  output logic                  m_sel_skid,
  output logic                  clr
);

  pipe_state_t              state_r;
  pipe_state_t              next_state_s;
  logic                     rdy_r;
  logic                     val_r;
  logic [PIPE_CNT_W-1:0]    count_r;
  logic                     in_fire_s;
  logic                     out_fire_s;

  assign in_fire_s   = istream_val & rdy_r;
  assign out_fire_s  = val_r & ostream_rdy;
  assign istream_rdy = rdy_r;
  assign ostream_val = val_r;
  assign count       = count_r;

  // Next-state and data-register write enables
  always_comb begin
    next_state_s = state_r;
    m_en         = 1'b0;
    s_en         = 1'b0;
    m_sel_skid   = 1'b0;
    clr          = 1'b0;
    if (rst || squash) begin
      next_state_s = PIPE_EMPTY;
      clr          = 1'b1;
    end else begin
      case (state_r)
        PIPE_EMPTY: begin
          if (in_fire_s) begin
            m_en         = 1'b1;
            next_state_s = PIPE_BUSY;
          end else begin
            next_state_s = PIPE_EMPTY;
          end
        end
        PIPE_BUSY: begin
          if (in_fire_s && out_fire_s) begin
            m_en         = 1'b1;
            next_state_s = PIPE_BUSY;
          end else if (in_fire_s) begin
            s_en         = 1'b1;
            next_state_s = PIPE_FULL;
          end else if (out_fire_s) begin
            next_state_s = PIPE_EMPTY;
          end else begin
            next_state_s = PIPE_BUSY;
          end
        end
        PIPE_FULL: begin
          // Upstream is stalled here, so only the drain path exists
          if (out_fire_s) begin
            m_en         = 1'b1;
            m_sel_skid   = 1'b1;
            next_state_s = PIPE_BUSY;
          end else begin
            next_state_s = PIPE_FULL;
          end
        end
        default: begin
          next_state_s = PIPE_EMPTY;
          clr          = 1'b1;
        end
      endcase
    end
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PIPE_EMPTY;
      rdy_r   <= 1'b1;
      val_r   <= 1'b0;
      count_r <= {PIPE_CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      rdy_r   <= (next_state_s != PIPE_FULL);
      val_r   <= (next_state_s != PIPE_EMPTY);
      count_r <= next_state_s;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register: head entry M drives ostream, skid
// entry S absorbs one message when downstream stalls.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          p_nbits       = 32,
  parameter logic [p_nbits-1:0]   p_reset_value = {p_nbits{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  squash,
  input  logic                  istream_val,
  output logic                  istream_rdy,
  input  logic [p_nbits-1:0]    istream_msg,
  output logic                  ostream_val,
  input  logic                  ostream_rdy,
  output logic [p_nbits-1:0]    ostream_msg,
  output logic [PIPE_CNT_W-1:0] count
);

  logic               m_en_s;
  logic               s_en_s;
  logic               m_sel_skid_s;
  logic               clr_s;
  logic [p_nbits-1:0] m_r;
  logic [p_nbits-1:0] s_r;
  logic [p_nbits-1:0] m_next_s;

  pipe_skid_reg_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .squash      (squash),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .count       (count),
    .m_en        (m_en_s),
    .s_en        (s_en_s),
    .m_sel_skid  (m_sel_skid_s),
    .clr         (clr_s)
  );

  // Head entry source: refill from skid when draining FULL, else upstream
  always_comb begin
    if (m_sel_skid_s) begin
      m_next_s = s_r;
    end else begin
      m_next_s = istream_msg;
    end
  end

  // Data entries; written only on the enables from the controller
  always_ff @(posedge clk) begin
    if (clr_s) begin
      m_r <= p_reset_value;
      s_r <= p_reset_value;
    end else begin
      if (m_en_s) begin
        m_r <= m_next_s;
      end
      if (s_en_s) begin
        s_r <= istream_msg;
      end
    end
  end

  assign ostream_msg = m_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a random
// val/rdy soak, all checked every cycle against a queue-based model.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       squash;
  logic       istream_val;
  logic       istream_rdy;
  logic [7:0] istream_msg;
  logic       ostream_val;
  logic       ostream_rdy;
  logic [7:0] ostream_msg;
  logic [1:0] count;

  logic [7:0] q[$];
  logic [7:0] idle_msg;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.p_nbits(8), .p_reset_value(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .squash      (squash),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .count       (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model view: occupancy is the queue length; an empty block shows the last
  // consumed payload, or the reset value after a clear.
  task automatic model_check();
    logic [7:0] exp_msg;
    exp_msg = (q.size() > 0) ? q[0] : idle_msg;
    chk("rdy",   {31'd0, istream_rdy}, (q.size() < 2) ? 32'd1 : 32'd0);
    chk("val",   {31'd0, ostream_val}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("count", {30'd0, count},       q.size());
    chk("msg",   {24'd0, ostream_msg}, {24'd0, exp_msg});
  endtask

  task automatic cycle(input logic v, input logic [7:0] m, input logic ordy,
                       input logic sq, input logic r);
    bit in_fire;
    bit out_fire;
    istream_val = v;
    istream_msg = m;
    ostream_rdy = ordy;
    squash      = sq;
    rst         = r;
    @(posedge clk);
    if (r || sq) begin
      q.delete();
      idle_msg = 8'hA5;
    end else begin
      in_fire  = v && (q.size() < 2);
      out_fire = ordy && (q.size() > 0);
      if (out_fire) idle_msg = q.pop_front();
      if (in_fire)  q.push_back(m);
    end
    @(negedge clk);
    model_check();
  endtask

  initial begin
    istream_val = 1'b0;
    istream_msg = 8'h00;
    ostream_rdy = 1'b0;
    squash      = 1'b0;
    rst         = 1'b1;
    idle_msg    = 8'hA5;

    // Reset then idle
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_rdy",   {31'd0, istream_rdy}, 32'd1);
    chk("rst_val",   {31'd0, ostream_val}, 32'd0);
    chk("rst_count", {30'd0, count},       32'd0);
    chk("rst_msg",   {24'd0, ostream_msg}, 32'hA5);

    // Streaming: each message visible the cycle after acceptance
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_msg",   {24'd0, ostream_msg}, i);
      chk("stream_count", {30'd0, count},       32'd1);
      chk("stream_rdy",   {31'd0, istream_rdy}, 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_count", {30'd0, count}, 32'd0);

    // Backpressure into the skid entry, then drain
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("skid_count", {30'd0, count},       32'd2);
    chk("skid_rdy",   {31'd0, istream_rdy}, 32'd0);
    chk("skid_msg",   {24'd0, ostream_msg}, 32'h11);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("skid_out2",  {24'd0, ostream_msg}, 32'h22);
    chk("skid_cnt1",  {30'd0, count},       32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("skid_cnt0",  {30'd0, count},       32'd0);

    // Squash while FULL with a simultaneous offered message
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("sq_count", {30'd0, count},       32'd0);
    chk("sq_val",   {31'd0, ostream_val}, 32'd0);
    chk("sq_msg",   {24'd0, ostream_msg}, 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sq_after", {31'd0, ostream_val}, 32'd0);

    // Reset mid-stream alongside an accepted message
    cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    chk("mid_busy", {24'd0, ostream_msg}, 32'h66);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("mid_count", {30'd0, count},       32'd0);
    chk("mid_msg",   {24'd0, ostream_msg}, 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mid_after", {31'd0, ostream_val}, 32'd0);

    // Random val/rdy soak with rare squash and reset
    for (int n = 0; n < 1000; n++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
